// File: rtl/furv_pkg.sv
// Shared types and bus constants for the furv data-side Wishbone bridge.
package furv_pkg;

    localparam int FURV_ADDR_W = 30;
    localparam int FURV_DATA_W = 32;
    localparam int FURV_SEL_W  = 4;

    // Word handed back to the core when a cycle ends in error or timeout
    localparam logic [FURV_DATA_W-1:0] FURV_BUS_ERR_DATA = 32'h0;

    // Word handed back to the core when a store completes
    localparam logic [FURV_DATA_W-1:0] FURV_STORE_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } furv_state_e;

endpackage

// File: rtl/furv_wb_watchdog.sv
// Stall watchdog for the furv Wishbone bridge: counts bus cycles that have
// not terminated and pulses expired on the TIMEOUT-th such cycle.
module furv_wb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic running,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Clear when a cycle is launched, then count each unterminated bus cycle
    always_ff @(posedge clk) begin
        if (rst || start) begin
            cnt <= '0;
        end else if (running && (cnt != LIMIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // cnt equals TIMEOUT-1 during the TIMEOUT-th bus cycle
    assign expired = running && (cnt == LIMIT);

endmodule

// File: rtl/furv_wb_bridge.sv
// furv core load/store port to Wishbone B4 classic master bridge.
// One outstanding transaction, all outputs registered.
// Optional stall watchdog enabled by defining FURV_WB_TIMEOUT_EN.
module furv_wb_bridge
    import furv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   core_mem,
    input  logic                   core_mem_write,
    input  logic [FURV_ADDR_W-1:0] core_addr,
    input  logic [FURV_SEL_W-1:0]  core_sel,
    input  logic [FURV_DATA_W-1:0] core_data_out,
    output logic [FURV_DATA_W-1:0] core_data_in,
    output logic                   core_ack,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [FURV_ADDR_W-1:0] wb_adr_o,
    output logic [FURV_SEL_W-1:0]  wb_sel_o,
    output logic [FURV_DATA_W-1:0] wb_dat_o,
    input  logic [FURV_DATA_W-1:0] wb_dat_i,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    output logic                   bus_error
);

    furv_state_e state;
    logic        bus_fail;

`ifdef FURV_WB_TIMEOUT_EN
    logic wd_start;
    logic wd_running;
    logic wd_expired;

    assign wd_start   = (state == IDLE) && core_mem;
    assign wd_running = (state == BUS);

    furv_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (wd_start),
        .running (wd_running),
        .expired (wd_expired)
    );

    // Error termination: slave error, or watchdog expiry unless a real ack lands
    always_comb begin
        bus_fail = wb_err_i | (wd_expired & ~wb_ack_i);
    end
`else
    // Without the watchdog a stalled slave holds the bus and TIMEOUT has no role
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;

    // Error termination comes only from the slave
    always_comb begin
        bus_fail = wb_err_i;
    end
`endif

    // Request/bus/retire sequencer with registered core and Wishbone outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_sel_o     <= '0;
            wb_dat_o     <= '0;
            core_ack     <= 1'b0;
            core_data_in <= '0;
            bus_error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    core_ack <= 1'b0;
                    if (core_mem) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= core_mem_write;
                        wb_adr_o <= core_addr;
                        wb_sel_o <= core_sel;
                        wb_dat_o <= core_data_out;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    // Error wins over a simultaneous ack
                    if (bus_fail) begin
                        wb_cyc_o     <= 1'b0;
                        wb_stb_o     <= 1'b0;
                        core_data_in <= FURV_BUS_ERR_DATA;
                        bus_error    <= 1'b1;
                        core_ack     <= 1'b1;
                        state        <= DONE;
                    end else if (wb_ack_i) begin
                        wb_cyc_o     <= 1'b0;
                        wb_stb_o     <= 1'b0;
                        core_data_in <= wb_we_o ? FURV_STORE_DATA : wb_dat_i;
                        core_ack     <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    // core_mem still belongs to the retiring instruction here
                    core_ack <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_furv_wb_bridge.sv
// Self-checking bench for furv_wb_bridge: a transaction-level model queues the
// expected per-cycle outputs of each request; one compare process checks them.
module tb_furv_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_mem;
    logic        core_mem_write;
    logic [29:0] core_addr;
    logic [3:0]  core_sel;
    logic [31:0] core_data_out;
    logic [31:0] core_data_in;
    logic        core_ack;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [29:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i;
    logic        bus_error;

    localparam int TO = 8;

    furv_wb_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .core_mem(core_mem), .core_mem_write(core_mem_write),
        .core_addr(core_addr), .core_sel(core_sel), .core_data_out(core_data_out),
        .core_data_in(core_data_in), .core_ack(core_ack),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        cyc;
        bit        we;
        bit [29:0] adr;
        bit [3:0]  sel;
        bit [31:0] dat;
        bit        ack;
        bit [31:0] rd;
        bit        berr;
        bit        rstv;
    } exp_t;

    exp_t  expq[$];
    int    nvec  = 0;
    int    nfail = 0;
    bit    chk_en = 1'b0;
    bit    model_err = 1'b0;
    int    ack_cnt = 0;
    logic [31:0] last_rd = '0;

    // slave behaviour: terminate on bus cycle index slv_waits with slv_kind
    int          slv_waits = 0;
    int          slv_kind  = 0;
    logic [31:0] slv_rd    = '0;
    int          bcnt      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Reactive slave, driven on the falling edge
    always @(negedge clk) begin
        if (wb_cyc_o === 1'b1) begin
            if (bcnt == slv_waits) begin
                wb_ack_i = (slv_kind == 0 || slv_kind == 2);
                wb_err_i = (slv_kind == 1 || slv_kind == 2);
                wb_dat_i = slv_rd;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = $urandom;
            end
            bcnt++;
        end else begin
            bcnt     = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = $urandom;
        end
    end

    // Compare DUT outputs against the queued expectation every cycle
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            if (expq.size() > 0) begin
                e = expq.pop_front();
            end else begin
                e = '{cyc:0, we:0, adr:0, sel:0, dat:0, ack:0, rd:0, berr:model_err, rstv:0};
            end
            chk("cyc", {31'd0, wb_cyc_o}, {31'd0, e.cyc});
            chk("stb", {31'd0, wb_stb_o}, {31'd0, e.cyc});
            chk("core_ack", {31'd0, core_ack}, {31'd0, e.ack});
            chk("bus_error", {31'd0, bus_error}, {31'd0, e.berr});
            if (e.cyc || e.rstv) begin
                chk("wb_we", {31'd0, wb_we_o}, {31'd0, e.we});
                chk("wb_adr", {2'd0, wb_adr_o}, {2'd0, e.adr});
                chk("wb_sel", {28'd0, wb_sel_o}, {28'd0, e.sel});
                chk("wb_dat", wb_dat_o, e.dat);
            end
            if (e.ack || e.rstv) chk("core_data_in", core_data_in, e.rd);
            if (core_ack === 1'b1) begin
                ack_cnt++;
                last_rd = core_data_in;
            end
        end
    end

    function automatic exp_t bus_rec(input bit we, input bit [29:0] a, input bit [3:0] s,
                                     input bit [31:0] d, input bit berr);
        bus_rec = '{cyc:1, we:we, adr:a, sel:s, dat:d, ack:0, rd:0, berr:berr, rstv:0};
    endfunction

    // One request; kind 0 ack, 1 err, 2 err+ack, 3 no termination (watchdog)
    task automatic req(input logic [29:0] a, input logic [3:0] s, input logic [31:0] d,
                       input bit we, input int waits, input int kind, input logic [31:0] rd);
        int nb;
        nb = (kind == 3) ? TO : waits + 1;
        slv_waits = (kind == 3) ? 32'h4000_0000 : waits;
        slv_kind  = kind;
        slv_rd    = rd;
        core_mem = 1'b1; core_mem_write = we; core_addr = a; core_sel = s; core_data_out = d;
        expq.push_back('{cyc:0, we:0, adr:0, sel:0, dat:0, ack:0, rd:0, berr:model_err, rstv:0});
        for (int i = 0; i < nb; i++) expq.push_back(bus_rec(we, a, s, d, model_err));
        if (kind != 0) model_err = 1'b1;
        expq.push_back('{cyc:0, we:0, adr:0, sel:0, dat:0, ack:1,
                         rd:((kind == 0 && !we) ? rd : 32'h0), berr:model_err, rstv:0});
        for (int i = 0; i < nb + 2; i++) begin
            @(posedge clk); #1;
            if (i < nb + 1) begin
                // core side may wander while the access is in flight
                core_mem_write = $urandom_range(0, 1);
                core_addr = $urandom; core_sel = $urandom; core_data_out = $urandom;
            end
        end
    endtask

    task automatic idle(input int n);
        core_mem = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Start a never-terminated request and reset it during bus cycle nbus
    task automatic req_abort(input logic [29:0] a, input int nbus);
        slv_waits = 32'h4000_0000;
        slv_kind  = 3;
        core_mem = 1'b1; core_mem_write = 1'b0; core_addr = a; core_sel = 4'hF;
        core_data_out = 32'h1234_5678;
        expq.push_back('{cyc:0, we:0, adr:0, sel:0, dat:0, ack:0, rd:0, berr:model_err, rstv:0});
        for (int i = 0; i < nbus; i++) expq.push_back(bus_rec(1'b0, a, 4'hF, 32'h1234_5678, model_err));
        model_err = 1'b0;
        expq.push_back('{cyc:0, we:0, adr:0, sel:0, dat:0, ack:0, rd:0, berr:0, rstv:1});
        repeat (nbus) begin @(posedge clk); #1; end
        rst = 1'b1; core_mem = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int acks0;
        rst = 1'b1; core_mem = 1'b0; core_mem_write = 1'b0; core_addr = '0;
        core_sel = '0; core_data_out = '0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        expq.push_back('{cyc:0, we:0, adr:0, sel:0, dat:0, ack:0, rd:0, berr:0, rstv:1});
        chk_en = 1'b1;
        idle(2);

        // zero-wait load
        req(30'h100, 4'hF, 32'h0, 1'b0, 0, 0, 32'hCAFEF00D);
        idle(1);
        chk("load_rd_literal", last_rd, 32'hCAFEF00D);
        chk("load_ack_count", ack_cnt, 1);

        // byte store with 3 wait states
        req(30'h2A, 4'b0100, 32'h00AB0000, 1'b1, 3, 0, 32'hDEAD_BEEF);
        idle(1);
        chk("store_rd_literal", last_rd, 32'h0);

        // back-to-back with core_mem held
        acks0 = ack_cnt;
        req(30'h10, 4'hF, 32'h0, 1'b0, 0, 0, 32'h1111_0010);
        req(30'h11, 4'hF, 32'h0, 1'b0, 0, 0, 32'h1111_0011);
        idle(2);
        chk("b2b_ack_count", ack_cnt - acks0, 2);

        // err and ack together on a load
        req(30'h3F, 4'hF, 32'h0, 1'b0, 1, 2, 32'h5555_AAAA);
        idle(2);
        chk("err_rd_literal", last_rd, 32'h0);
        chk("err_sticky_literal", {31'd0, bus_error}, 32'd1);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            int r, k, g;
            r = $urandom_range(0, 9);
            k = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            req($urandom, $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 4), k, $urandom);
            g = $urandom_range(0, 2);
            if (g != 0) idle(g);
        end
        idle(1);

`ifdef FURV_WB_TIMEOUT_EN
        // slave never responds: watchdog terminates after TO bus cycles
        req(30'h77, 4'hF, 32'h0, 1'b0, 0, 3, 32'h0);
        idle(1);
        chk("timeout_rd_literal", last_rd, 32'h0);
        chk("timeout_berr_literal", {31'd0, bus_error}, 32'd1);
`else
        // slave never responds: bus stays held, then cleared by reset
        acks0 = ack_cnt;
        req_abort(30'h77, 1000);
        idle(1);
        chk("hang_no_ack", ack_cnt - acks0, 0);
`endif

        // reset during the second bus cycle
        req(30'h5, 4'h3, 32'h0, 1'b0, 0, 1, 32'h0);
        idle(1);
        acks0 = ack_cnt;
        req_abort(30'h123, 2);
        idle(3);
        chk("abort_no_ack", ack_cnt - acks0, 0);
        chk("abort_berr_literal", {31'd0, bus_error}, 32'd0);

        // normal traffic after reset
        req(30'h200, 4'hF, 32'h0, 1'b0, 2, 0, 32'h0BAD_F00D);
        idle(2);
        chk("post_reset_rd_literal", last_rd, 32'h0BAD_F00D);
        chk("queue_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/furv_wb_bridge.md
# furv_wb_bridge

Data-side bus adapter sitting directly downstream of the furv core's load/store port. It turns the core's level-held request (mem, mem_write, word address, byte selects, write data) into a registered Wishbone B4 classic master cycle. It returns read data plus a one-cycle ack that the core uses to retire the memory instruction. Slave errors are reported, and an optional watchdog bounds stalled cycles.

## Interface
- TIMEOUT, 255: watchdog limit in cycles of wb_cyc_o high without termination; used only with the timeout feature.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- core_mem  in  1  core requests a memory access; held until core_ack
- core_mem_write  in  1  1 = store, 0 = load
- core_addr  in  30  word address (byte address [31:2])
- core_sel  in  4  byte lane selects, already shifted by the core
- core_data_out  in  32  store data, already lane-aligned by the core
- core_data_in  out  32  read data to the core, whole word (core extracts lanes)
- core_ack  out  1  request complete; high exactly one cycle per request
- wb_cyc_o, wb_stb_o  out  1 each  Wishbone cycle/strobe, always driven equal
- wb_we_o  out  1  write enable
- wb_adr_o  out  30  word address
- wb_sel_o  out  4  byte selects
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error termination
- bus_error  out  1  sticky; set on any error or timeout termination

## Operation
- States: IDLE, BUS, DONE.
- IDLE: core_ack=0, wb_cyc_o=0. If core_mem=1, latch core_addr/core_sel/core_data_out/core_mem_write into the wb_* output registers and go to BUS.
- BUS: wb_cyc_o=wb_stb_o=1, all wb_* outputs stable.
  - On wb_err_i=1: capture 32'h0 and set bus_error. err has priority over ack in the same cycle.
  - On wb_ack_i=1: capture wb_dat_i if a load, 32'h0 if a store.
  - Either termination drops cyc/stb and goes to DONE.
- DONE: core_ack=1, core_data_in = captured word. Go to IDLE unconditionally. core_mem is ignored in DONE; it still belongs to the retiring instruction.
- Core inputs are sampled only in IDLE. Changes while in BUS/DONE have no effect.
- bus_error is cleared only by rst.

## Timing
- Reset values: all wb_* outputs 0, core_ack 0, core_data_in 0, bus_error 0, state IDLE.
- Minimum latency, zero-wait slave (wb_ack_i high in the first BUS cycle):
  - core_mem rises in cycle 0, BUS in cycle 1, core_ack in cycle 2.
  - The core retires at the end of cycle 2, so a memory instruction costs 3 cycles.
- Each slave wait state adds one cycle.
- Back-to-back accesses: a new request is accepted in the IDLE cycle right after DONE. No overlap, one outstanding transaction.
- No combinational path from wb_* inputs to core outputs, or from core inputs to wb_* outputs. All outputs are registered.
- rst during BUS: wb_cyc_o/wb_stb_o are 0 from the next cycle (cycle abort). No core_ack is produced and no capture occurs.

## Configuration
- FURV_WB_TIMEOUT_EN defined:
  - A counter clears on entry to BUS and increments each BUS cycle without termination.
  - When it reaches TIMEOUT, the cycle ends as if wb_err_i were asserted: drop cyc/stb, return 32'h0, set bus_error, go to DONE.
  - A genuine ack in the same cycle as the limit wins.
- Undefined: no counter is instantiated; BUS waits indefinitely and TIMEOUT is unused.

## Structure
- furv_pkg holds:
  - state typedef (IDLE, BUS, DONE)
  - FURV_BUS_ERR_DATA = 32'h0
  - bus width constants (address 30, data 32, sel 4)
- One sub-module, furv_wb_watchdog, holds the timeout counter. Instantiate it only under FURV_WB_TIMEOUT_EN. Output: one-cycle expired pulse; inputs: start, running.

## Test plan
- Load, zero-wait slave: core_addr=30'h100, core_sel=4'hF, wb_dat_i=32'hCAFEF00D.
  - wb_adr_o=30'h100 and cyc high in cycle 1.
  - core_ack=1 with core_data_in=32'hCAFEF00D in cycle 2.
  - core_ack=0 in cycle 3.
- Byte store with 3 wait states: core_sel=4'b0100, core_data_out=32'h00AB0000.
  - wb_we_o=1, wb_sel_o=4'b0100, wb_dat_o=32'h00AB0000 held 4 cycles.
  - core_ack one cycle later, core_data_in=0.
- Back-to-back: core_mem held high across two requests to 30'h10 and 30'h11.
  - Two separate cyc pulses with one IDLE cycle between.
  - Exactly two core_ack pulses.
- Error: wb_err_i and wb_ack_i both high in the same cycle.
  - core_data_in=0, bus_error=1 and stays 1 until rst.
- Timeout (macro defined, TIMEOUT=8): slave never acks.
  - cyc drops after 8 BUS cycles, core_ack follows, bus_error=1.
  - With the macro undefined, cyc stays high for 1000 cycles.
- rst asserted in the second BUS cycle:
  - cyc/stb 0 on the following cycle, no core_ack, all outputs at reset values.
